// File: rtl/count_stream_checker.sv
// Stream monitor: checks accepted count samples increment by one, locks on clean runs.
// Optional COUNT_CHECK_STICKY_EN adds err_sticky and holds lock once an error is seen.
module count_stream_checker #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned LOCK_LEN    = 4,
  parameter int unsigned UNLOCK_ERRS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             count_valid,
  input  logic [WIDTH-1:0] in_value,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] sample_count,
`ifdef COUNT_CHECK_STICKY_EN
  output logic             err_sticky,
`endif
  output logic [WIDTH-1:0] expected
);

  localparam int unsigned    RUN_W      = 4;
  localparam logic [RUN_W-1:0] LOCK_TGT   = RUN_W'(LOCK_LEN);
  localparam logic [RUN_W-1:0] UNLOCK_TGT = RUN_W'(UNLOCK_ERRS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_locked;
  logic               r_err_pulse;
  logic [ERR_W-1:0]   r_err_count;
  logic [ERR_W-1:0]   r_sample_count;
  logic [WIDTH-1:0]   r_expected;
  logic [RUN_W-1:0]   r_good_run;
  logic [RUN_W-1:0]   r_bad_run;
  logic               r_err_sticky;

  logic               w_accept;
  logic               w_match;
  logic [RUN_W-1:0]   w_good_nxt;
  logic [RUN_W-1:0]   w_bad_nxt;
  logic               w_hold_lock;

  assign w_accept   = enable & count_valid;
  assign w_match    = (in_value == r_expected);
  assign w_good_nxt = r_good_run + RUN_W'(1);
  // bad_run can grow without bound when lock is held, so it saturates
  assign w_bad_nxt  = (&r_bad_run) ? r_bad_run : r_bad_run + RUN_W'(1);

`ifdef COUNT_CHECK_STICKY_EN
  // any LOCKED mismatch sets the sticky flag, which pins the lock
  assign w_hold_lock = 1'b1;
  assign err_sticky  = r_err_sticky;
`else
  assign w_hold_lock = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state        <= ST_IDLE;
      r_locked       <= 1'b0;
      r_err_pulse    <= 1'b0;
      r_err_count    <= '0;
      r_sample_count <= '0;
      r_expected     <= '0;
      r_good_run     <= '0;
      r_bad_run      <= '0;
      r_err_sticky   <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (w_accept) begin
        if (!(&r_sample_count)) r_sample_count <= r_sample_count + ERR_W'(1);
        // always resynchronise to the sample just seen
        r_expected <= in_value + WIDTH'(1);
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_ACQUIRE;
            r_good_run <= '0;
          end
          ST_ACQUIRE: begin
            if (w_match) begin
              r_good_run <= w_good_nxt;
              if (w_good_nxt == LOCK_TGT) begin
                r_state   <= ST_LOCKED;
                r_bad_run <= '0;
                r_locked  <= 1'b1;
              end
            end else begin
              r_good_run <= '0;
            end
          end
          ST_LOCKED: begin
            if (w_match) begin
              r_bad_run <= '0;
            end else begin
              r_err_pulse  <= 1'b1;
              r_err_sticky <= 1'b1;
              if (!(&r_err_count)) r_err_count <= r_err_count + ERR_W'(1);
              r_bad_run <= w_bad_nxt;
              if ((w_bad_nxt == UNLOCK_TGT) && !w_hold_lock) begin
                r_state    <= ST_ACQUIRE;
                r_good_run <= '0;
                r_locked   <= 1'b0;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign locked       = r_locked;
  assign err_pulse    = r_err_pulse;
  assign err_count    = r_err_count;
  assign sample_count = r_sample_count;
  assign expected     = r_expected;

endmodule

// File: tb/tb_count_stream_checker.sv
// Scoreboard bench for count_stream_checker; define COUNT_CHECK_STICKY_EN to test the sticky build.
module tb_count_stream_checker;

  localparam int unsigned LOCK_LEN    = 4;
  localparam int unsigned UNLOCK_ERRS = 2;
`ifdef COUNT_CHECK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct packed {
    logic        lock;
    logic        pulse;
    logic [15:0] err;
    logic [15:0] smp;
    logic [7:0]  exp;
    logic        sticky;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       count_valid = 1'b0;
  logic [7:0] in_value = '0;
  logic       clear = 1'b0;
  logic       locked;
  logic       err_pulse;
  logic [15:0] err_count;
  logic [15:0] sample_count;
  logic [7:0]  expected;
  logic        sticky_obs;

  count_stream_checker #(
    .WIDTH(8), .ERR_W(16), .LOCK_LEN(LOCK_LEN), .UNLOCK_ERRS(UNLOCK_ERRS)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .count_valid(count_valid),
    .in_value(in_value), .clear(clear), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .sample_count(sample_count),
`ifdef COUNT_CHECK_STICKY_EN
    .err_sticky(sticky_obs),
`endif
    .expected(expected)
  );

`ifndef COUNT_CHECK_STICKY_EN
  assign sticky_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  obs_t sb[$];

  // reference model state
  int         m_state = 0;  // 0 idle, 1 acquire, 2 locked
  int         m_good = 0;
  int         m_bad = 0;
  logic [7:0] m_exp = '0;
  logic [15:0] m_err = '0;
  logic [15:0] m_smp = '0;
  logic       m_lock = 1'b0;
  logic       m_pulse = 1'b0;
  logic       m_sticky = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, want, $time);
  endtask

  task automatic model(input bit rst, input bit clr, input bit en, input bit vld,
                       input logic [7:0] val);
    if (rst || clr) begin
      m_state = 0; m_good = 0; m_bad = 0; m_exp = '0; m_err = '0; m_smp = '0;
      m_lock = 1'b0; m_pulse = 1'b0; m_sticky = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (en && vld) begin
        if (m_smp != 16'hFFFF) m_smp = m_smp + 16'd1;
        if (m_state == 0) begin
          m_state = 1;
          m_good  = 0;
        end else if (m_state == 1) begin
          if (val == m_exp) begin
            m_good++;
            if (m_good == LOCK_LEN) begin m_state = 2; m_bad = 0; m_lock = 1'b1; end
          end else m_good = 0;
        end else begin
          if (val == m_exp) m_bad = 0;
          else begin
            m_pulse = 1'b1;
            if (STICKY) m_sticky = 1'b1;
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
            m_bad++;
            if (!STICKY && m_bad == UNLOCK_ERRS) begin
              m_state = 1; m_good = 0; m_lock = 1'b0;
            end
          end
        end
        m_exp = val + 8'd1;
      end
    end
  endtask

  // One cycle: score the previous cycle's outputs, then drive new inputs and predict
  task automatic step(input bit rst, input bit clr, input bit en, input bit vld,
                      input logic [7:0] val);
    obs_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("locked",       32'(locked),       32'(e.lock));
      chk("err_pulse",    32'(err_pulse),    32'(e.pulse));
      chk("err_count",    32'(err_count),    32'(e.err));
      chk("sample_count", 32'(sample_count), 32'(e.smp));
      chk("expected",     32'(expected),     32'(e.exp));
      chk("err_sticky",   32'(sticky_obs),   32'(e.sticky));
    end
    reset = rst; clear = clr; enable = en; count_valid = vld; in_value = val;
    model(rst, clr, en, vld, val);
    sb.push_back('{lock: m_lock, pulse: m_pulse, err: m_err, smp: m_smp,
                   exp: m_exp, sticky: m_sticky});
  endtask

  task automatic feed(input logic [7:0] val);
    step(1'b0, 1'b0, 1'b1, 1'b1, val);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] v;
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h55);
    idle();
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_expected", 32'(expected), 32'd0);

    // seed and lock
    for (int i = 0; i < 5; i++) feed(8'h10 + 8'(i));
    idle();
    chk("lock_locked", 32'(locked), 32'd1);
    chk("lock_samples", 32'(sample_count), 32'd5);
    chk("lock_expected", 32'(expected), 32'h15);
    chk("lock_errs", 32'(err_count), 32'd0);

    // wrap-around
    feed(8'hFE); feed(8'hFF); feed(8'h00); feed(8'h01);
    idle();
    chk("wrap_expected", 32'(expected), 32'h02);
    chk("wrap_locked", 32'(locked), 32'd1);

    // single glitches
    feed(8'h20); feed(8'h21); feed(8'h30); feed(8'h31);
    idle();
    chk("glitch_expected", 32'(expected), 32'h32);
    chk("glitch_locked", 32'(locked), 32'd1);

    // unlock (non-sticky) and relock
    feed(8'h40); feed(8'h50); feed(8'h60);
    idle();
    chk("unlock_locked", 32'(locked), 32'(STICKY));
    for (int i = 1; i <= 4; i++) feed(8'h60 + 8'(i));
    idle();
    chk("relock_locked", 32'(locked), 32'd1);

    // gating: valid low, then enable low with junk values
    repeat (20) idle();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
    v = m_exp;
    for (int i = 0; i < 4; i++) feed(v + 8'(i));
    idle();
    chk("gate_locked", 32'(locked), 32'd1);

    // reset mid-run, then the next sample is only a seed
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h99);
    idle();
    chk("midrst_errs", 32'(err_count), 32'd0);
    feed(8'hA7);
    idle();
    chk("seed_pulse", 32'(err_pulse), 32'd0);
    chk("seed_expected", 32'(expected), 32'hA8);

    // relock, then clear coinciding with an accept
    for (int i = 0; i < 4; i++) feed(8'hA8 + 8'(i));
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h33);
    feed(8'h70);
    feed(8'h01);

    // random stream with gaps and occasional discontinuities
    v = 8'($urandom);
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 10)      idle();
      else if (r < 15) step(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
      else if (r < 22) begin feed(8'($urandom)); v = m_exp; end
      else if (r < 23) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      else begin feed(v); v = v + 8'd1; end
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
